seq_gen_5bit: RTL and testbench

SEQ_GEN_5BIT -- requirements
Module: seq_gen_5bit

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_gen_5bit_if.sv | 42 ++++
 rtl/seq_piso5.sv | 31 +++
 rtl/seq_gen_5bit.sv | 147 ++++++++++++++
 tb/tb_seq_gen_5bit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared widths and state encoding for the 5-bit serial pattern generator.
package seq_pkg;

  localparam int PAT_W = 5;
  localparam int REP_W = 3;
  localparam int GAP_W = 2;
  localparam int IDX_W = 3;

  // Index of the first bit sent in every frame (MSB first).
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_gen_5bit_if.sv
// Request/stream bundle between a pattern requester and the serial generator.
interface seq_gen_5bit_if;
  import seq_pkg::*;

  logic             pat_valid;
  logic             pat_ready;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             data;
  logic             data_valid;
  logic             busy;
  logic             done;

  modport master (
    output pat_valid,
    output pattern,
    output repeat_cnt,
    output gap,
    output abort,
    input  pat_ready,
    input  data,
    input  data_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  pat_valid,
    input  pattern,
    input  repeat_cnt,
    input  gap,
    input  abort,
    output pat_ready,
    output data,
    output data_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/seq_piso5.sv
// Loadable parallel-in/serial-out register; the MSB is the registered serial output.
module seq_piso5
  import seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [PAT_W-1:0] din,
  output logic             dout
);

  logic [PAT_W-1:0] sreg;

  // Clear wins so the line returns to 0 the cycle after any frame ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg <= '0;
    end else if (clear) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[PAT_W-2:0], 1'b0};
    end
  end

  assign dout = sreg[PAT_W-1];

endmodule

// File: rtl/seq_gen_5bit.sv
// Serializes a captured 5-bit pattern MSB first, repeated with optional idle gaps.
module seq_gen_5bit
  import seq_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  seq_gen_5bit_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] pat_next;
  logic [REP_W-1:0] reps_q;
  logic [REP_W-1:0] reps_next;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_next;
  logic [GAP_W-1:0] gap_left_q;
  logic [GAP_W-1:0] gap_left_next;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_next;
  logic             dv_q;
  logic             dv_next;
  logic             piso_load;
  logic             piso_shift;
  logic             piso_clear;
  logic [PAT_W-1:0] piso_din;
  logic             accept;

  // An abort presented together with a request cancels the request.
  assign accept = (state == ST_IDLE) && bus.pat_valid && !bus.abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pat_q      <= '0;
      reps_q     <= '0;
      gap_q      <= '0;
      gap_left_q <= '0;
      idx_q      <= '0;
      dv_q       <= 1'b0;
    end else begin
      state      <= state_next;
      pat_q      <= pat_next;
      reps_q     <= reps_next;
      gap_q      <= gap_next;
      gap_left_q <= gap_left_next;
      idx_q      <= idx_next;
      dv_q       <= dv_next;
    end
  end

  always_comb begin
    state_next    = state;
    pat_next      = pat_q;
    reps_next     = reps_q;
    gap_next      = gap_q;
    gap_left_next = gap_left_q;
    idx_next      = idx_q;
    dv_next       = 1'b0;
    piso_load     = 1'b0;
    piso_shift    = 1'b0;
    piso_clear    = 1'b0;
    piso_din      = pat_q;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SHIFT;
          pat_next   = bus.pattern;
          reps_next  = bus.repeat_cnt;
          gap_next   = bus.gap;
          idx_next   = IDX_MSB;
          piso_load  = 1'b1;
          piso_din   = bus.pattern;
          dv_next    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bus.abort) begin
          state_next = ST_IDLE;
          idx_next   = '0;
          piso_clear = 1'b1;
        end else if (idx_q != '0) begin
          idx_next   = idx_q - IDX_W'(1);
          piso_shift = 1'b1;
          dv_next    = 1'b1;
        end else if (reps_q == '0) begin
          state_next = ST_DONE;
          piso_clear = 1'b1;
        end else if (gap_q == '0) begin
          // Back-to-back frame: reload straight from the captured pattern.
          reps_next  = reps_q - REP_W'(1);
          idx_next   = IDX_MSB;
          piso_load  = 1'b1;
          dv_next    = 1'b1;
        end else begin
          state_next    = ST_GAP;
          gap_left_next = gap_q;
          piso_clear    = 1'b1;
        end
      end

      ST_GAP: begin
        if (bus.abort) begin
          state_next    = ST_IDLE;
          gap_left_next = '0;
        end else if (gap_left_q == GAP_W'(1)) begin
          state_next    = ST_SHIFT;
          gap_left_next = '0;
          reps_next     = reps_q - REP_W'(1);
          idx_next      = IDX_MSB;
          piso_load     = 1'b1;
          dv_next       = 1'b1;
        end else begin
          gap_left_next = gap_left_q - GAP_W'(1);
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        piso_clear = 1'b1;
      end
    endcase
  end

  seq_piso5 u_piso (
    .clock (clock),
    .reset (reset),
    .load  (piso_load),
    .shift (piso_shift),
    .clear (piso_clear),
    .din   (piso_din),
    .dout  (bus.data)
  );

  assign bus.data_valid = dv_q;
  assign bus.pat_ready  = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);

endmodule

// File: tb/tb_seq_gen_5bit.sv
// Table-driven and scoreboard-based bench for the serial pattern generator.
module tb_seq_gen_5bit;

  typedef struct {
    logic dv;
    logic data;
    logic done;
    logic busy;
  } exp_t;

  typedef struct {
    logic [4:0] pattern;
    logic [2:0] repeat_cnt;
    logic [1:0] gap;
    int         exp_valid;
    int         exp_busy;
    int         exp_det;
  } vec_t;

  logic clock;
  logic reset;

  seq_gen_5bit_if bus ();

  seq_gen_5bit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t       exp_q[$];
  vec_t       vecs[6];
  int         pass_cnt;
  int         total_cnt;
  int         valid_seen;
  int         busy_seen;
  int         det_hits;
  int         det_bits;
  logic [4:0] det_win;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive a request just after a negedge and push the expected per-cycle trace.
  task automatic apply_stimulus(input logic [4:0] p, input logic [2:0] r, input logic [1:0] g);
    exp_t e;
    bus.pattern    = p;
    bus.repeat_cnt = r;
    bus.gap        = g;
    bus.pat_valid  = 1'b1;
    for (int f = 0; f <= int'(r); f++) begin
      for (int b = 4; b >= 0; b--) begin
        e = '{dv: 1'b1, data: p[b], done: 1'b0, busy: 1'b1};
        exp_q.push_back(e);
      end
      if (f < int'(r)) begin
        for (int k = 0; k < int'(g); k++) begin
          e = '{dv: 1'b0, data: 1'b0, done: 1'b0, busy: 1'b1};
          exp_q.push_back(e);
        end
      end
    end
    e = '{dv: 1'b0, data: 1'b0, done: 1'b1, busy: 1'b1};
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    bus.pat_valid  = 1'b0;
    bus.pattern    = ~p;
    bus.repeat_cnt = r + 3'd1;
    bus.gap        = g + 2'd1;
  endtask

  task automatic pop_compare(input string name, input logic [4:0] det_pat);
    exp_t e;
    e = exp_q.pop_front();
    check({name, "_out"},
          {28'd0, bus.data_valid, bus.data, bus.done, bus.busy},
          {28'd0, e.dv, e.data, e.done, e.busy});
    if (bus.busy) busy_seen++;
    if (bus.data_valid) begin
      valid_seen++;
      det_win = {det_win[3:0], bus.data};
      det_bits++;
      if (det_bits >= 5 && det_win == det_pat) det_hits++;
    end
  endtask

  // abort_kind: 1 cancels (expect IDLE next), 2 is an abort the DUT must ignore.
  task automatic check_output(input string name, input int poke_cycle, input int abort_kind,
                              input int abort_cycle, input logic [4:0] det_pat);
    int cyc;
    cyc        = 0;
    valid_seen = 0;
    busy_seen  = 0;
    det_hits   = 0;
    det_bits   = 0;
    det_win    = '0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      cyc++;
      bus.pat_valid = 1'b0;
      bus.abort     = 1'b0;
      pop_compare(name, det_pat);
      if (cyc == poke_cycle) begin
        check({name, "_ready_while_busy"}, 32'(bus.pat_ready), 32'd0);
        bus.pat_valid = 1'b1;
        bus.pattern   = 5'b11111;
      end
      if (abort_kind != 0 && cyc == abort_cycle) begin
        bus.abort = 1'b1;
        if (abort_kind == 1) exp_q.delete();
      end
    end
    @(negedge clock);
    bus.pat_valid = 1'b0;
    bus.abort     = 1'b0;
    check({name, "_idle_after"},
          {28'd0, bus.pat_ready, bus.busy, bus.data_valid, bus.done}, 32'h8);
  endtask

  task automatic check_quiet(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check({name, "_quiet"},
            {28'd0, bus.data_valid, bus.data, bus.done, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clock          = 1'b0;
    reset          = 1'b1;
    bus.pat_valid  = 1'b0;
    bus.pattern    = '0;
    bus.repeat_cnt = '0;
    bus.gap        = '0;
    bus.abort      = 1'b0;
    pass_cnt       = 0;
    total_cnt      = 0;

    vecs[0] = '{5'b10101, 3'd0, 2'd0, 5, 6, 1};
    vecs[1] = '{5'b10001, 3'd2, 2'd0, 15, 16, 3};
    vecs[2] = '{5'b10101, 3'd1, 2'd3, 10, 14, 2};
    vecs[3] = '{5'b11111, 3'd7, 2'd1, 40, 48, 36};
    vecs[4] = '{5'b00000, 3'd3, 2'd2, 20, 27, 16};
    vecs[5] = '{5'b01101, 3'd0, 2'd3, 5, 6, 1};

    repeat (2) @(negedge clock);
    check("reset_state",
          {27'd0, bus.pat_ready, bus.busy, bus.data_valid, bus.data, bus.done}, 32'h10);
    reset = 1'b0;

    // First request issued right after reset release must be taken on the first edge.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].pattern, vecs[i].repeat_cnt, vecs[i].gap);
      check_output($sformatf("vec%0d", i), 0, 0, 0, vecs[i].pattern);
      check($sformatf("vec%0d_valid_cycles", i), 32'(valid_seen), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_seen), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_detector", i), 32'(det_hits), 32'(vecs[i].exp_det));
    end

    $display("[TB] request while busy");
    apply_stimulus(5'b10001, 3'd0, 2'd0);
    check_output("intrude", 3, 0, 0, 5'b10001);
    check("intrude_detector", 32'(det_hits), 32'd1);
    check_quiet("intrude", 6);

    $display("[TB] asynchronous reset mid-frame");
    apply_stimulus(5'b10101, 3'd0, 2'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      pop_compare("rst_pre", 5'b10101);
    end
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_clear",
          {28'd0, bus.data_valid, bus.data, bus.done, bus.busy}, 32'd0);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("rst_ready_after", 32'(bus.pat_ready), 32'd1);
    check_quiet("rst", 8);

    $display("[TB] abort in gap");
    apply_stimulus(5'b10101, 3'd1, 2'd3);
    check_output("abort_gap", 0, 1, 7, 5'b10101);
    check("abort_gap_valid_cycles", 32'(valid_seen), 32'd5);
    check_quiet("abort_gap", 8);

    $display("[TB] abort in done");
    apply_stimulus(5'b10101, 3'd0, 2'd0);
    check_output("abort_done", 0, 2, 6, 5'b10101);

    $display("[TB] abort with request in idle");
    bus.abort     = 1'b1;
    bus.pat_valid = 1'b1;
    bus.pattern   = 5'b10101;
    @(negedge clock);
    check("abort_idle_no_accept",
          {30'd0, bus.busy, bus.data_valid}, 32'd0);
    bus.abort     = 1'b0;
    bus.pat_valid = 1'b0;
    check_quiet("abort_idle", 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
